// File: rtl/calc_scan_ctrl_pkg.sv
// Shared types and constants for the calculator scan controller.
package calc_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] DIG_A   = 2'd3;
    localparam logic [1:0] DIG_B   = 2'd2;
    localparam logic [1:0] DIG_OP  = 2'd1;
    localparam logic [1:0] DIG_RES = 2'd0;

    localparam int SCAN_DIV_DEF = 100000;

endpackage

// File: rtl/calc_scan_ctrl_scan_timer.sv
// Free-running scan divider; emits a wrap tick and rotates the digit index on each wrap.
module fnd_scan_timer
    import calc_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic       o_tick,
    output logic [1:0] o_digit
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;

    assign o_tick  = (cnt_q == CNT_MAX);
    assign o_digit = digit_q;

    always_comb begin
        cnt_d   = o_tick ? '0 : cnt_q + CW'(1);
        digit_d = o_tick ? digit_q + 2'd1 : digit_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            digit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/calc_scan_ctrl.sv
// Calculator sequencer: latches operands, captures the result and multiplexes
// the four values onto a scanned 7-segment display.
module calc_scan_ctrl
    import calc_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [1:0] i_selOperator,
    input  logic       i_start,
    input  logic [3:0] i_result,
    output logic [3:0] o_calcA,
    output logic [3:0] o_calcB,
    output logic [1:0] o_calcOp,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_digitSelect,
    output logic [3:0] o_value,
    output logic       o_en
);

    state_e     state_q, state_d;
    logic [3:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0] op_q, op_d;
    logic       res_valid_q, res_valid_d;
    logic       busy_q, busy_d, done_q, done_d;
    logic [3:0] value_q, value_d;
    logic       en_q, en_d;

    logic       scan_tick;
    logic [1:0] digit, digit_nxt;

    fnd_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (scan_tick),
        .o_digit (digit)
    );

    // busy/done are decoded from the next state so they are registered alongside it
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (i_start) begin
                state_d = LOAD;
                busy_d  = 1'b1;
            end
            LOAD: begin
                a_d     = i_a;
                b_d     = i_b;
                op_d    = i_selOperator;
                state_d = EVAL;
                busy_d  = 1'b1;
            end
            EVAL: begin
                res_d       = i_result;
                res_valid_d = 1'b1;
                state_d     = DONE;
                busy_d      = 1'b1;
                done_d      = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Mux from next-cycle digit and source values so the display tracks them with no extra lag
    always_comb begin
        digit_nxt = scan_tick ? digit + 2'd1 : digit;
        value_d   = res_d;
        en_d      = res_valid_d;
        case (digit_nxt)
            DIG_A:  begin value_d = a_d;           en_d = 1'b1; end
            DIG_B:  begin value_d = b_d;           en_d = 1'b1; end
            DIG_OP: begin value_d = {2'b00, op_d}; en_d = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            value_q     <= '0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            value_q     <= value_d;
            en_q        <= en_d;
        end
    end

    assign o_calcA       = a_q;
    assign o_calcB       = b_q;
    assign o_calcOp      = op_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_digitSelect = digit;
    assign o_value       = value_q;
    assign o_en          = en_q;

endmodule
